// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
//
// The optional checksum byte is enabled by the LOADER_CHECKSUM_EN macro.
// Without that macro the CHECK state does not exist, and a finished load
// goes straight to DONE.
package loader_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BITS       = 8 * LEN_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } loader_state_t;

  // State entered once the last word is written, or when the length is zero.
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t FINISH_STATE = CHECK;
`else
  localparam loader_state_t FINISH_STATE = DONE;
`endif

endpackage

// File: rtl/word_assembler.sv
// Builds one little-endian 32-bit word from a stream of bytes.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - drops any partly built word (used when a session starts)
//   byte_en     - byte_in is accepted this cycle
//   byte_in     - incoming byte; the first byte of a word ends up in bits [7:0]
//   word        - the word as assembled so far
//   word_full   - high in the cycle that the last byte of a word is accepted
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + CW'(1);
      // Each new byte goes in at the top, so after four bytes the first
      // one has moved down into bits [7:0].
      word     <= {byte_in, word[31:8]};
    end
  end

  assign word_full = byte_en && (byte_cnt == CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Program loader: takes in a length-prefixed byte stream and writes
// 32-bit words into program memory.
//
// Stream format: L (16 bits, low byte first), then L words, each sent low
// byte first. When LOADER_CHECKSUM_EN is defined, one more byte follows:
// the XOR of all the data bytes.
//
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   start          - one-cycle pulse that begins a session (taken in IDLE/DONE/ERR)
//   rx_data        - incoming byte
//   rx_valid       - rx_data is valid this cycle
//   rx_ready       - the loader accepts a byte this cycle
//   byte_address   - memory write address (valid while write_enable is high)
//   write_enable   - one-cycle memory write strobe
//   write_data     - memory write word
//   busy/done/error- session status
//   word_count     - number of words written in the current or last session
//
// state  | meaning
// IDLE   | waiting for the first start after reset
// LEN_LO | waiting for the low length byte
// LEN_HI | waiting for the high length byte; decides DATA / finish / ERR
// DATA   | collecting the bytes of a word
// WRITE  | one-cycle memory write of the assembled word
// CHECK  | waiting for the checksum byte (only with LOADER_CHECKSUM_EN)
// DONE   | session finished successfully
// ERR    | session aborted (length too large or checksum mismatch)
module program_loader
  import loader_pkg::*;
#(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] byte_address,
  output logic        write_enable,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  loader_state_t state, state_nxt;

  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] len_full;
  logic                accept;
  logic                start_ok;
  logic                last_word;
  logic [31:0]         asm_word;
  logic                word_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
  assign len_full  = {rx_data, len_q[7:0]};
  assign last_word = (word_count + 16'd1) == len_q;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .byte_en   (accept && state == DATA),
    .byte_in   (rx_data),
    .word      (asm_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_ok) begin
      state_nxt = LEN_LO;
    end else begin
      case (state)
        LEN_LO: if (accept) state_nxt = LEN_HI;
        LEN_HI: begin
          if (accept) begin
            if (len_full == '0)
              state_nxt = FINISH_STATE;
            else if (32'(len_full) > $unsigned(32'(MEM_WORDS)))
              state_nxt = ERR;
            else
              state_nxt = DATA;
          end
        end
        DATA:   if (accept && word_full) state_nxt = WRITE;
        WRITE:  state_nxt = last_word ? FINISH_STATE : DATA;
`ifdef LOADER_CHECKSUM_EN
        CHECK:  if (accept) state_nxt = (rx_data == csum) ? DONE : ERR;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      len_q      <= '0;
      word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      if (accept && state == LEN_LO) len_q[7:0]  <= rx_data;
      if (accept && state == LEN_HI) len_q[15:8] <= rx_data;
      if (state == WRITE)            word_count  <= word_count + 16'd1;
`ifdef LOADER_CHECKSUM_EN
      if (accept && state == DATA)   csum        <= csum ^ rx_data;
`endif
    end
  end

  always_comb begin
    rx_ready     = 1'b0;
    write_enable = 1'b0;
    byte_address = '0;
    write_data   = '0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      LEN_LO, LEN_HI, DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        busy         = 1'b1;
        write_enable = 1'b1;
        // Wraps modulo 2^32 on its own because the sum is 32 bits wide.
        byte_address = BASE_ADDR + {14'd0, word_count, 2'b00};
        write_data   = asm_word;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      DONE:    done  = 1'b1;
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. A scoreboard queue holds the expected
// memory writes (address, data). Each entry is pushed once the last byte of
// its word has been sent, and is popped when the loader strobes write_enable.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] byte_address;
  logic        write_enable;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int n_chk = 0;
  int n_bad = 0;
  int n_wr  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] words[$];

  program_loader #(.MEM_WORDS(256), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .byte_address (byte_address),
    .write_enable (write_enable),
    .write_data   (write_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (write_enable) begin
      logic [63:0] e;
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {31'd0, write_enable}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", byte_address, e[63:32]);
        chk("wr_data", write_data, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    @(negedge clk);
    if (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      chk("ready_timeout", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", {31'd0, done | error}, 32'd1);
  endtask

  // Sends a complete session made of the first nw entries of words[].
  task automatic do_load(input int nw, input bit gap, input bit bad_cs);
    logic [7:0]  cs = 8'h00;
    logic [15:0] len = nw[15:0];
    logic [31:0] w;
    pulse_start();
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    for (int i = 0; i < nw; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], gap);
        cs = cs ^ w[8*b +: 8];
      end
      exp_q.push_back({BASE + 32'(4 * i), w});
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_cs ? (cs ^ 8'hFF) : cs, gap);
`else
    if (bad_cs) cs = 8'h00;
`endif
    wait_end();
  endtask

  initial begin
    int wr0;

    // After reset, every output is 0.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_we",    {31'd0, write_enable}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, error}, 32'd0);
    chk("rst_addr",  byte_address, 32'd0);
    chk("rst_data",  write_data, 32'd0);
    chk("rst_wc",    {16'd0, word_count}, 32'd0);
    reset = 1'b0;

    // Two words, sent back to back.
    words = '{32'h00200093, 32'h00A00513};
    wr0 = n_wr;
    do_load(2, 1'b0, 1'b0);
    chk("two_done", {31'd0, done}, 32'd1);
    chk("two_err",  {31'd0, error}, 32'd0);
    chk("two_wc",   {16'd0, word_count}, 32'd2);
    chk("two_nwr",  n_wr - wr0, 32'd2);
    chk("two_pend", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    chk("done_hold", {31'd0, done}, 32'd1);

    // Zero length: no writes at all.
    wr0 = n_wr;
    do_load(0, 1'b0, 1'b0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_wc",   {16'd0, word_count}, 32'd0);
    chk("zero_nwr",  n_wr - wr0, 32'd0);

    // Length 257 is larger than MEM_WORDS, so the session is aborted.
    wr0 = n_wr;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    wait_end();
    chk("big_err",  {31'd0, error}, 32'd1);
    chk("big_done", {31'd0, done}, 32'd0);
    chk("big_busy", {31'd0, busy}, 32'd0);
    chk("big_nwr",  n_wr - wr0, 32'd0);
    repeat (3) @(negedge clk);
    chk("err_hold", {31'd0, error}, 32'd1);

    // Three words with rx_valid going low on every other cycle.
    words = '{32'hDEADBEEF, 32'h12345678, 32'hA5C30F81};
    wr0 = n_wr;
    do_load(3, 1'b1, 1'b0);
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_wc",   {16'd0, word_count}, 32'd3);
    chk("gap_nwr",  n_wr - wr0, 32'd3);
    chk("gap_pend", exp_q.size(), 32'd0);

    // Reset after two bytes of the first word.
    wr0 = n_wr;
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_busy",  {31'd0, busy}, 32'd0);
    chk("mid_ready", {31'd0, rx_ready}, 32'd0);
    chk("mid_we",    {31'd0, write_enable}, 32'd0);
    chk("mid_done",  {31'd0, done}, 32'd0);
    chk("mid_err",   {31'd0, error}, 32'd0);
    chk("mid_wc",    {16'd0, word_count}, 32'd0);
    chk("mid_addr",  byte_address, 32'd0);
    chk("mid_data",  write_data, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_nwr", n_wr - wr0, 32'd0);

    // After the reset, a fresh word must not contain any leftover bytes.
    words = '{32'hCAFEF00D};
    do_load(1, 1'b0, 1'b0);
    chk("post_done", {31'd0, done}, 32'd1);
    chk("post_wc",   {16'd0, word_count}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: the word is still written, then the session ends in ERR.
    words = '{32'h0badc0de};
    wr0 = n_wr;
    do_load(1, 1'b0, 1'b1);
    chk("cs_err",  {31'd0, error}, 32'd1);
    chk("cs_done", {31'd0, done}, 32'd0);
    chk("cs_nwr",  n_wr - wr0, 32'd1);
`endif

    chk("final_pend", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256, giving the program memory depth in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0, giving the byte address of word 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a load session.
REQ-006 The block SHALL have port rx_data, input, 8 bits: the incoming byte stream.
REQ-007 The block SHALL have port rx_valid, input, 1 bit: rx_data is valid this cycle.
REQ-008 The block SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have port byte_address, output, 32 bits: the program memory write address.
REQ-010 The block SHALL have port write_enable, output, 1 bit: the program memory write strobe.
REQ-011 The block SHALL have port write_data, output, 32 bits: the program memory write word.
REQ-012 The block SHALL have port busy, output, 1 bit: a session is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: the last session completed successfully.
REQ-014 The block SHALL have port error, output, 1 bit: the last session was aborted.
REQ-015 The block SHALL have port word_count, output, 16 bits: the number of words written in the current or last session.

Function
REQ-016 A byte SHALL be accepted only on a cycle where rx_valid and rx_ready are both high.
REQ-017 The stream format SHALL be: length L (16-bit word count, low byte first), then L words, each sent least-significant byte first.
REQ-018 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE and ERR.
REQ-019 A start pulse in IDLE, DONE or ERR SHALL move the FSM to LEN_LO and clear word_count, done and error; start in any other state SHALL be ignored.
REQ-020 rx_ready SHALL be high only in LEN_LO, LEN_HI, DATA and CHECK.
REQ-021 After the high length byte is accepted: L=0 SHALL go to CHECK (or to DONE when the macro is absent); L>MEM_WORDS SHALL go to ERR; any other L SHALL go to DATA.
REQ-022 In DATA, acceptance of the 4th byte of a word SHALL move the FSM to WRITE on the next edge.
REQ-023 In WRITE, write_enable SHALL be high for exactly one cycle, with byte_address = BASE_ADDR + 4*word_count and write_data holding the assembled word.
REQ-024 The write address SHALL be computed modulo 2^32.
REQ-025 On leaving WRITE, word_count SHALL increment, and the FSM SHALL go to CHECK/DONE when word_count reaches L, otherwise back to DATA.
REQ-026 write_enable SHALL be low in every state other than WRITE.
REQ-027 The minimum throughput SHALL be 5 cycles per word (4 accept cycles plus 1 WRITE cycle).
REQ-028 busy SHALL be high in LEN_LO through CHECK; done SHALL be high only in DONE; error SHALL be high only in ERR.
REQ-029 done and error SHALL be held until the next start or reset.

Reset
REQ-030 Reset SHALL force IDLE, with rx_ready, write_enable, busy, done and error all 0, and byte_address, write_data and word_count all 0.
REQ-031 Reset mid-session SHALL abort the session with no further write; words already written remain in memory.
REQ-032 A partially assembled word SHALL be discarded on reset.

Configuration
REQ-033 With LOADER_CHECKSUM_EN defined, one extra byte SHALL follow the data: the XOR of all bytes after the length bytes (L=0 gives 8'h00).
REQ-034 With LOADER_CHECKSUM_EN defined, the FSM SHALL accept that byte in CHECK and go to DONE on a match, or to ERR on a mismatch.
REQ-035 With LOADER_CHECKSUM_EN undefined, CHECK and the checksum register SHALL be absent, and completion SHALL go directly to DONE.

Structure
REQ-036 The package loader_pkg SHALL hold the state enum loader_state_t and the constants LEN_BYTES=2 and BYTES_PER_WORD=4.
REQ-037 The sub-module word_assembler SHALL hold the byte counter and the 32-bit little-endian shift register, and SHALL signal word_full.

Verification
REQ-038 The bench SHALL cover: start, then bytes 02 00 93 00 20 00 13 05 A0 00 -> two writes: addr 0x0 data 0x00200093, then addr 0x4 data 0x00A00513; done=1, word_count=2.
REQ-039 The bench SHALL cover: length 00 00 -> no write; done=1 (with the macro, checksum byte 00 is also required).
REQ-040 The bench SHALL cover: length 01 01 (257) with MEM_WORDS=256 -> ERR, error=1, no write.
REQ-041 The bench SHALL cover: rx_valid toggled 0/1 every cycle during a 3-word load -> the same writes as gap-free streaming, one write_enable pulse per word.
REQ-042 The bench SHALL cover: reset asserted after 2 bytes of word 1 -> IDLE next cycle, no write, all outputs 0.
REQ-043 The bench SHALL cover, with LOADER_CHECKSUM_EN defined: a 1-word load with a wrong checksum -> the word is written, then error=1 and done=0.
